eth_pkt_arbiter: RTL and testbench
==================================

// Module: eth_pkt_arbiter
// PURPOSE
// - Packet-level round-robin arbiter sharing one downstream 34-bit stream between two Ethernet
//   receive FSMs (port A, port B).
// - Each port writes {eop,sop,data[31:0]} words into its own input FIFO.
// - Arbiter grants whole packets (SOP..EOP, never interleaved) to the output under out_ready backpressure.
// PARAMETERS
// - DEPTH  16  words per input FIFO (power of 2, >=4)
// - AW     4   FIFO pointer width, log2(DEPTH)
// - DW     34  word width: bit33=EOP, bit32=SOP, bits31:0=data
// PORTS
// - clk          in   1   single clock, all logic on posedge
// - rstN         in   1   asynchronous active-low reset
// - a_wr_en      in   1   port A word strobe
// - a_data_in    in   DW  port A word
// - b_wr_en      in   1   port B word strobe
// - b_data_in    in   DW  port B word
// - out_ready    in   1   downstream accepts word this cycle
// - out_valid    out  1   out_data valid
// - out_data     out  DW  granted word
// - a_full       out  1   port A FIFO holds DEPTH words
// - b_full       out  1   port B FIFO holds DEPTH words
// - a_ovf        out  1   sticky: port A word dropped on full
// - b_ovf        out  1   sticky: port B word dropped on full
// - orphan_err   out  1   1-cycle pulse: non-SOP head word flushed in IDLE
// BEHAVIOUR
// - Reset (async, rstN=0): FIFO pointers/counts=0; state=IDLE; last_grant=B (A wins first tie).
//   All outputs 0. A partial packet in flight is lost; out_valid drops immediately.
// - FIFO write: x_wr_en && !x_full pushes x_data_in at posedge.
// - Write while full: word discarded; x_ovf set, cleared only by reset.
// - Read and write in the same cycle on a full FIFO: write is still dropped (full is registered).
// - Transfer = out_valid && out_ready; pops the head of the granted FIFO.
// - FSM states: IDLE, GRANT_A, GRANT_B.
// - IDLE, request: port x requests when its FIFO is non-empty and head bit32 (SOP)=1.
//   - Only one requests: go to GRANT_x.
//   - Both request: grant the port != last_grant.
//   - Neither requests: stay IDLE.
// - IDLE, orphan head: a non-empty FIFO whose head has SOP=0 pops that head this cycle
//   and pulses orphan_err.
//   - Both ports orphaned: both pop, one pulse.
//   - Orphan port cannot be granted that cycle; the other port may be.
// - GRANT_x: out_valid = FIFO_x non-empty; out_data = FIFO_x head (combinational mux).
//   - Non-granted port keeps accepting writes.
//   - FIFO_x empty mid-packet: out_valid=0, grant held (no timeout).
//   - Transfer of a word with bit33 (EOP)=1: go to IDLE, last_grant<=x.
//   - SOP seen inside a granted packet is passed through unchanged.
// - Single-word packet (SOP=EOP=1): one transfer, then IDLE.
// - IDLE: out_valid=0, out_data=0.
// - Latency: word pushed at edge N into idle arbiter -> grant at edge N+1 -> out_valid from N+1.
//   Minimum 1 idle bubble cycle between packets.
// - Fairness: with both ports continuously loaded, grants alternate A,B,A,B per packet.
// - Count width AW+1 so full (count==DEPTH) and empty are unambiguous; pointers wrap modulo DEPTH.
// CONFIGURATION
// - Macro ETH_ARB_DROP_CNT_EN.
// - Defined: adds outputs a_drop_cnt[15:0] and b_drop_cnt[15:0].
//   - Each increments per word dropped on full and saturates at 16'hFFFF.
//   - Reset to 0.
// - Not defined: counters and ports absent; a_ovf/b_ovf behaviour unchanged.
// TESTING
// - Reset then idle: all outputs 0, out_valid stays 0 for 20 cycles.
// - A sends 4-word pkt (SOP 32'hABCD, 2 data, EOP), out_ready=1:
//   - 4 transfers in order, bits33:32 = 01,00,00,10.
//   - out_valid first high 1 cycle after first push.
// - A and B each queue one 3-word pkt in the same cycle:
//   - output carries all A words, then 1 bubble, then all B words; no interleave.
//   - Repeat: B first then A.
// - Backpressure: out_ready toggles 1/0 during a 6-word B pkt:
//   - out_data held stable while out_ready=0; all 6 words delivered exactly once.
// - Overflow: out_ready=0, push 18 words into A (DEPTH=16):
//   - a_full=1 after 16; a_ovf=1 after 17.
//   - 2 words lost; a_drop_cnt=2 with ETH_ARB_DROP_CNT_EN.
// - Orphan and reset: push a word with SOP=0 into idle B -> orphan_err pulses, FIFO empties;
//   assert rstN=0 mid-packet -> out_valid=0 immediately, FIFOs empty.

Source files
------------

// File: rtl/eth_pkt_arbiter.sv
// Packet-level round-robin arbiter: two input FIFOs (ports A/B) share one 34-bit output stream.
// Optional per-port drop counters are enabled by defining ETH_ARB_DROP_CNT_EN.
module eth_pkt_arbiter #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 34
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          a_wr_en,
    input  logic [DW-1:0] a_data_in,
    input  logic          b_wr_en,
    input  logic [DW-1:0] b_data_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          a_full,
    output logic          b_full,
    output logic          a_ovf,
    output logic          b_ovf,
`ifdef ETH_ARB_DROP_CNT_EN
    output logic [15:0]   a_drop_cnt,
    output logic [15:0]   b_drop_cnt,
`endif
    output logic          orphan_err
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          last_grant_reg;  // 0 = A, 1 = B
    logic          xfer;

    logic [1:0]    wr_en;
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    ovf;
    logic [1:0]    pop;
    logic [1:0]    req;
    logic [1:0]    orphan;
    logic [DW-1:0] wr_data [2];
    logic [DW-1:0] head    [2];
`ifdef ETH_ARB_DROP_CNT_EN
    logic [15:0]   drop_cnt [2];
`endif

    assign wr_en      = {b_wr_en, a_wr_en};
    assign wr_data[0] = a_data_in;
    assign wr_data[1] = b_data_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DW-1:0] mem [DEPTH];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [AW:0]   cnt_reg;
            logic          ovf_reg;
            logic          push;

            // Full comes from the registered count, so a pop in the same cycle does not free a slot.
            assign push        = wr_en[gi] && !full[gi];
            assign full[gi]    = (cnt_reg == FULL_CNT);
            assign empty[gi]   = (cnt_reg == '0);
            assign head[gi]    = mem[rd_ptr_reg];
            assign ovf[gi]     = ovf_reg;
            assign req[gi]     = !empty[gi] && head[gi][32];
            assign orphan[gi]  = (state_reg == IDLE) && !empty[gi] && !head[gi][32];

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= wr_data[gi];
                end
            end

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                    ovf_reg    <= 1'b0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    end
                    if (push && !pop[gi]) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else if (!push && pop[gi]) begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                    if (wr_en[gi] && full[gi]) begin
                        ovf_reg <= 1'b1;
                    end
                end
            end

`ifdef ETH_ARB_DROP_CNT_EN
            logic [15:0] drop_cnt_reg;

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    drop_cnt_reg <= '0;
                end else if (wr_en[gi] && full[gi] && (drop_cnt_reg != 16'hFFFF)) begin
                    drop_cnt_reg <= drop_cnt_reg + 16'd1;
                end
            end

            assign drop_cnt[gi] = drop_cnt_reg;
`endif
        end
    endgenerate

    // Orphaned heads are flushed in IDLE; granted FIFOs pop on each accepted word.
    assign pop[0] = orphan[0] || ((state_reg == GRANT_A) && !empty[0] && out_ready);
    assign pop[1] = orphan[1] || ((state_reg == GRANT_B) && !empty[1] && out_ready);
    assign xfer   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (xfer && out_data[33]) begin
                last_grant_reg <= (state_reg == GRANT_B);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req[0] && req[1]) begin
                    state_next = last_grant_reg ? GRANT_A : GRANT_B;
                end else if (req[0]) begin
                    state_next = GRANT_A;
                end else if (req[1]) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (xfer && out_data[33]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid  = 1'b0;
        out_data   = '0;
        orphan_err = |orphan;
        case (state_reg)
            GRANT_A: begin
                out_valid = !empty[0];
                out_data  = head[0];
            end
            GRANT_B: begin
                out_valid = !empty[1];
                out_data  = head[1];
            end
            default: begin
                out_valid = 1'b0;
                out_data  = '0;
            end
        endcase
    end

    assign a_full = full[0];
    assign b_full = full[1];
    assign a_ovf  = ovf[0];
    assign b_ovf  = ovf[1];
`ifdef ETH_ARB_DROP_CNT_EN
    assign a_drop_cnt = drop_cnt[0];
    assign b_drop_cnt = drop_cnt[1];
`endif

endmodule

// File: tb/tb_eth_pkt_arbiter.sv
// Directed self-checking bench for eth_pkt_arbiter: packet order, fairness, backpressure,
// overflow, orphan flush and asynchronous reset.
module tb_eth_pkt_arbiter;
    localparam int DW = 34;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          a_wr_en = 1'b0;
    logic [DW-1:0] a_data_in = '0;
    logic          b_wr_en = 1'b0;
    logic [DW-1:0] b_data_in = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          a_full, b_full, a_ovf, b_ovf, orphan_err;
`ifdef ETH_ARB_DROP_CNT_EN
    logic [15:0]   a_drop_cnt, b_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW-1:0] got[$];
    int            got_cyc[$];

    eth_pkt_arbiter dut (
        .clk        (clk),
        .rstN       (rstN),
        .a_wr_en    (a_wr_en),
        .a_data_in  (a_data_in),
        .b_wr_en    (b_wr_en),
        .b_data_in  (b_data_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .a_full     (a_full),
        .b_full     (b_full),
        .a_ovf      (a_ovf),
        .b_ovf      (b_ovf),
`ifdef ETH_ARB_DROP_CNT_EN
        .a_drop_cnt (a_drop_cnt),
        .b_drop_cnt (b_drop_cnt),
`endif
        .orphan_err (orphan_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted word (transfer completes on the following posedge).
    always @(negedge clk) begin
        if (rstN && out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
            $display("xfer cyc=%0d data=%h", cyc, out_data);
        end
    end

    function automatic logic [DW-1:0] mk(input logic eop, input logic sop, input logic [31:0] d);
        return {eop, sop, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, a_full, b_full, a_ovf, b_ovf, orphan_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_valid, out_data, a_full, b_full, a_ovf, b_ovf, orphan_err});
        end
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || orphan_err !== 1'b0 || out_data !== '0) begin
                errors++;
                $display("FAIL idle_quiet: cycle %0d got valid=%b data=%h expected 0", i, out_valid, out_data);
            end
        end
`ifdef ETH_ARB_DROP_CNT_EN
        checks++;
        if (a_drop_cnt !== 16'd0 || b_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %h/%h expected 0/0", a_drop_cnt, b_drop_cnt);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_single_pkt();
        logic [DW-1:0] w[4];
        w[0] = mk(1'b0, 1'b1, 32'hABCD);
        w[1] = mk(1'b0, 1'b0, 32'h1111);
        w[2] = mk(1'b0, 1'b0, 32'h2222);
        w[3] = mk(1'b1, 1'b0, 32'h3333);
        got.delete(); got_cyc.delete();
        out_ready = 1'b1;
        a_wr_en = 1'b1; a_data_in = w[0];
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got valid=%b expected 0", out_valid);
        end
        a_data_in = w[1];
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== w[0]) begin
            errors++;
            $display("FAIL latency_first: got valid=%b data=%h expected 1 %h", out_valid, out_data, w[0]);
        end
        a_data_in = w[2];
        tick();
        a_data_in = w[3];
        tick();
        a_wr_en = 1'b0;
        repeat (6) tick();
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL single_count: got %0d expected 4", got.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== w[k]) begin
                errors++;
                $display("FAIL single_word%0d: got %h expected %h", k, got[k], w[k]);
            end
        end
        $display("test_single_pkt done");
    endtask

    task automatic test_two_pkts(input bit b_first);
        logic [DW-1:0] wa[3];
        logic [DW-1:0] wb[3];
        logic [DW-1:0] exp_q[$];
        for (int i = 0; i < 3; i++) begin
            wa[i] = mk(i == 2, i == 0, 32'hA000_0000 + i);
            wb[i] = mk(i == 2, i == 0, 32'hB000_0000 + i);
        end
        got.delete(); got_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_wr_en = 1'b1; a_data_in = wa[i];
            b_wr_en = 1'b1; b_data_in = wb[i];
            tick();
        end
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(b_first ? wb[i] : wa[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(b_first ? wa[i] : wb[i]);
        checks++;
        if (got.size() !== 6) begin
            errors++;
            $display("FAIL two_count: got %0d expected 6", got.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL two_order%0d: got %h expected %h", k, got[k], exp_q[k]);
            end
        end
        checks++;
        if (got_cyc[2] - got_cyc[0] !== 2 || got_cyc[5] - got_cyc[3] !== 2 || got_cyc[3] - got_cyc[2] !== 2) begin
            errors++;
            $display("FAIL two_timing: got gaps %0d %0d %0d expected 2 2 2",
                     got_cyc[2] - got_cyc[0], got_cyc[3] - got_cyc[2], got_cyc[5] - got_cyc[3]);
        end
        $display("test_two_pkts b_first=%0d done", b_first);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[6];
        logic          held_valid;
        logic [DW-1:0] held_data;
        got.delete(); got_cyc.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w[i] = mk(i == 5, i == 0, 32'hB0B0_0000 + i);
            b_wr_en = 1'b1; b_data_in = w[i];
            tick();
        end
        b_wr_en = 1'b0;
        held_valid = 1'b0;
        held_data  = '0;
        for (int k = 0; k < 40 && got.size() < 6; k++) begin
            out_ready = (k % 2 == 0);
            @(negedge clk);
            if (held_valid) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%b data=%h expected 1 %h", out_valid, out_data, held_data);
                end
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (got.size() !== 6) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 6", got.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== w[k]) begin
                errors++;
                $display("FAIL bp_word%0d: got %h expected %h", k, got[k], w[k]);
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        got.delete(); got_cyc.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            a_wr_en = 1'b1; a_data_in = mk(i == 15, i == 0, 32'hC000_0000 + i);
            tick();
            checks++;
            if (a_full !== (i >= 15)) begin
                errors++;
                $display("FAIL ovf_full push%0d: got %b expected %b", i + 1, a_full, (i >= 15));
            end
            checks++;
            if (a_ovf !== (i >= 16)) begin
                errors++;
                $display("FAIL ovf_flag push%0d: got %b expected %b", i + 1, a_ovf, (i >= 16));
            end
        end
        a_wr_en = 1'b0;
`ifdef ETH_ARB_DROP_CNT_EN
        checks++;
        if (a_drop_cnt !== 16'd2 || b_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL drop_cnt: got %0d/%0d expected 2/0", a_drop_cnt, b_drop_cnt);
        end
`endif
        checks++;
        if (b_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b_ovf_quiet: got %b expected 0", b_ovf);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && got.size() < 16; k++) tick();
        repeat (3) tick();
        checks++;
        if (got.size() !== 16) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d expected 16", got.size());
        end
        checks++;
        if (got[0] !== mk(1'b0, 1'b1, 32'hC000_0000) || got[15] !== mk(1'b1, 1'b0, 32'hC000_000F)) begin
            errors++;
            $display("FAIL ovf_drain_ends: got %h %h expected %h %h", got[0], got[15],
                     mk(1'b0, 1'b1, 32'hC000_0000), mk(1'b1, 1'b0, 32'hC000_000F));
        end
        checks++;
        if (a_full !== 1'b0 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got full=%b ovf=%b expected 0 1", a_full, a_ovf);
        end
        $display("test_overflow done");
    endtask

    task automatic test_orphan_reset();
        got.delete(); got_cyc.delete();
        out_ready = 1'b1;
        b_wr_en = 1'b1; b_data_in = mk(1'b0, 1'b0, 32'h5555_0000);
        tick();
        b_wr_en = 1'b0;
        checks++;
        if (orphan_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL orphan_pulse: got err=%b valid=%b expected 1 0", orphan_err, out_valid);
        end
        tick();
        checks++;
        if (orphan_err !== 1'b0) begin
            errors++;
            $display("FAIL orphan_once: got %b expected 0", orphan_err);
        end
        b_wr_en = 1'b1; b_data_in = mk(1'b1, 1'b1, 32'h5555_0001);
        tick();
        b_wr_en = 1'b0;
        repeat (4) tick();
        checks++;
        if (got.size() !== 1 || got[0] !== mk(1'b1, 1'b1, 32'h5555_0001)) begin
            errors++;
            $display("FAIL orphan_flushed: got %0d words first %h expected 1 %h", got.size(), got[0],
                     mk(1'b1, 1'b1, 32'h5555_0001));
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_wr_en = 1'b1; a_data_in = mk(1'b0, i == 0, 32'hD000_0000 + i);
            tick();
        end
        a_wr_en = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midpkt_valid: got %b expected 1", out_valid);
        end
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b a_ovf=%b expected 0 0", out_valid, a_ovf);
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b0 || got.size() !== 1) begin
            errors++;
            $display("FAIL reset_empty: got valid=%b words=%0d expected 0 1", out_valid, got.size());
        end
        a_wr_en = 1'b1; a_data_in = mk(1'b1, 1'b1, 32'h7777_0000);
        tick();
        a_wr_en = 1'b0;
        repeat (4) tick();
        checks++;
        if (got.size() !== 2 || got[1] !== mk(1'b1, 1'b1, 32'h7777_0000)) begin
            errors++;
            $display("FAIL post_reset_pkt: got %0d words last %h expected 2 %h", got.size(), got[1],
                     mk(1'b1, 1'b1, 32'h7777_0000));
        end
        $display("test_orphan_reset done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_pkts(1'b0);
        test_single_pkt();
        test_two_pkts(1'b1);
        test_backpressure();
        test_overflow();
        test_orphan_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
